// File: rtl/ascon_pkg.sv
// Shared ASCON controller definitions: decryption FSM states and round-counter constants.
package ascon_pkg;

  localparam logic [3:0] ROUND_LAST     = 4'hB;
  localparam logic [3:0] ROUND_P6_START = 4'h6;

  typedef enum logic [4:0] {
    IDLE,
    INIT_START,
    INIT_RUN,
    INIT_END,
    END_INIT,
    AD_WAIT,
    AD_START,
    AD_RUN,
    AD_END,
    CT_WAIT,
    CT_START,
    CT_RUN,
    CT_END,
    FIN_START,
    FIN_RUN,
    FIN_END,
    TAG_CHECK,
    DONE
  } state_dec_t;

endpackage

// File: rtl/fsm_moore_decrypt_block_counter.sv
// Ciphertext block counter: 3-bit, synchronous clear, terminal flag on the last block.
module block_counter #(
  parameter int unsigned NB_CIPHER_BLOCKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] count,
  output logic       last
);

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (en)      count <= count + 3'd1;
  end

  assign last = (count == 3'(NB_CIPHER_BLOCKS - 1));

endmodule

// File: rtl/fsm_moore_decrypt.sv
// Moore controller sequencing the ASCON-128 datapath for decryption and reporting tag status.
module fsm_moore_decrypt
  import ascon_pkg::*;
#(
  parameter int unsigned NB_CIPHER_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] round_i,
  input  logic       data_valid_i,
  input  logic       tag_equal_i,
  output logic       input_mode_o,
  output logic       en_reg_state_o,
  output logic       bypass_xor_begin_o,
  output logic       bypass_xor_end_o,
  output logic       mode_xor_key_o,
  output logic       dec_mode_o,
  output logic       en_cpt_double_o,
  output logic       init_p12_o,
  output logic       init_p6_o,
  output logic       en_plain_o,
  output logic [2:0] block_index_o,
  output logic       end_initialisation_o,
  output logic       done_o,
  output logic       auth_ok_o
);

  state_dec_t state, next;
  logic       accept_start;
  logic       last_block;
  logic       at_last_round;

  assign accept_start  = start_i && (state == IDLE || state == DONE);
  assign at_last_round = (round_i == ROUND_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || accept_start) auth_ok_o <= 1'b0;
    else if (state == TAG_CHECK) auth_ok_o <= tag_equal_i;
  end

  block_counter #(
    .NB_CIPHER_BLOCKS(NB_CIPHER_BLOCKS)
  ) u_block_counter (
    .clk   (clock_i),
    .rst   (reset_i),
    .clear (accept_start),
    .en    (state == CT_END),
    .count (block_index_o),
    .last  (last_block)
  );

  always_comb begin
    next = state;
    unique case (state)
      IDLE:       if (start_i) next = INIT_START;
      INIT_START: next = INIT_RUN;
      INIT_RUN:   if (at_last_round) next = INIT_END;
      INIT_END:   next = END_INIT;
      END_INIT:   next = AD_WAIT;
      AD_WAIT:    if (data_valid_i) next = AD_START;
      AD_START:   next = AD_RUN;
      AD_RUN:     if (at_last_round) next = AD_END;
      AD_END:     next = CT_WAIT;
      // The final ciphertext block is absorbed by the finalisation permutation.
      CT_WAIT:    if (data_valid_i) next = last_block ? FIN_START : CT_START;
      CT_START:   next = CT_RUN;
      CT_RUN:     if (at_last_round) next = CT_END;
      CT_END:     next = CT_WAIT;
      FIN_START:  next = FIN_RUN;
      FIN_RUN:    if (at_last_round) next = FIN_END;
      FIN_END:    next = TAG_CHECK;
      TAG_CHECK:  next = DONE;
      DONE:       if (start_i) next = INIT_START;
      default:    next = IDLE;
    endcase
  end

  always_comb begin
    input_mode_o         = 1'b0;
    en_reg_state_o       = 1'b0;
    bypass_xor_begin_o   = 1'b1;
    bypass_xor_end_o     = 1'b1;
    mode_xor_key_o       = 1'b0;
    dec_mode_o           = 1'b0;
    en_cpt_double_o      = 1'b0;
    init_p12_o           = 1'b0;
    init_p6_o            = 1'b0;
    en_plain_o           = 1'b0;
    end_initialisation_o = 1'b0;
    done_o               = 1'b0;
    case (state)
      INIT_START: begin
        input_mode_o    = 1'b1;
        init_p12_o      = 1'b1;
        en_cpt_double_o = 1'b1;
        en_reg_state_o  = 1'b1;
      end
      INIT_RUN, AD_RUN, CT_RUN, FIN_RUN: begin
        en_cpt_double_o = 1'b1;
        en_reg_state_o  = 1'b1;
      end
      INIT_END, AD_END, FIN_END: begin
        en_reg_state_o   = 1'b1;
        bypass_xor_end_o = 1'b0;
      end
      END_INIT: end_initialisation_o = 1'b1;
      AD_START: begin
        bypass_xor_begin_o = 1'b0;
        init_p6_o          = 1'b1;
        en_cpt_double_o    = 1'b1;
        en_reg_state_o     = 1'b1;
      end
      CT_START: begin
        bypass_xor_begin_o = 1'b0;
        dec_mode_o         = 1'b1;
        en_plain_o         = 1'b1;
        init_p6_o          = 1'b1;
        en_cpt_double_o    = 1'b1;
        en_reg_state_o     = 1'b1;
      end
      CT_END: en_reg_state_o = 1'b1;
      FIN_START: begin
        bypass_xor_begin_o = 1'b0;
        dec_mode_o         = 1'b1;
        en_plain_o         = 1'b1;
        mode_xor_key_o     = 1'b1;
        init_p12_o         = 1'b1;
        en_cpt_double_o    = 1'b1;
        en_reg_state_o     = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_moore_decrypt.sv
// Directed bench for the ASCON decryption controller with a behavioural external round counter.
module tb_fsm_moore_decrypt;

  logic       clk = 1'b0;
  logic       rst, start, dv, tag_eq;
  logic [3:0] round;
  logic       input_mode, en_reg, bxb, bxe, mode_key, dec, en_cpt, p12, p6, en_plain;
  logic [2:0] block_index;
  logic       end_init, done, auth_ok;
  logic [12:0] outs;

  int errors = 0;
  int checks = 0;
  bit counting = 1'b0;
  int n_p12 = 0, n_p6 = 0, n_plain = 0, n_end_init = 0;

  // Packed outputs, MSB first: input_mode en_reg bxb bxe mode_key dec en_cpt p12 p6 en_plain end_init done auth_ok
  localparam logic [12:0] O_IDLE      = 13'h0600;
  localparam logic [12:0] O_INIT_ST   = 13'h1E60;
  localparam logic [12:0] O_RUN       = 13'h0E40;
  localparam logic [12:0] O_KEY_END   = 13'h0C00;
  localparam logic [12:0] O_END_INIT  = 13'h0604;
  localparam logic [12:0] O_AD_ST     = 13'h0A50;
  localparam logic [12:0] O_CT_ST     = 13'h0AD8;
  localparam logic [12:0] O_DONE_BAD  = 13'h0602;
  localparam logic [12:0] O_DONE_OK   = 13'h0603;

  always #5 clk = ~clk;

  fsm_moore_decrypt #(.NB_CIPHER_BLOCKS(4)) dut (
    .clock_i              (clk),
    .reset_i              (rst),
    .start_i              (start),
    .round_i              (round),
    .data_valid_i         (dv),
    .tag_equal_i          (tag_eq),
    .input_mode_o         (input_mode),
    .en_reg_state_o       (en_reg),
    .bypass_xor_begin_o   (bxb),
    .bypass_xor_end_o     (bxe),
    .mode_xor_key_o       (mode_key),
    .dec_mode_o           (dec),
    .en_cpt_double_o      (en_cpt),
    .init_p12_o           (p12),
    .init_p6_o            (p6),
    .en_plain_o           (en_plain),
    .block_index_o        (block_index),
    .end_initialisation_o (end_init),
    .done_o               (done),
    .auth_ok_o            (auth_ok)
  );

  assign outs = {input_mode, en_reg, bxb, bxe, mode_key, dec, en_cpt, p12, p6, en_plain,
                 end_init, done, auth_ok};

  // External round counter as found in the datapath.
  always @(posedge clk) begin
    if (rst)         round <= 4'h0;
    else if (p12)    round <= 4'h0;
    else if (p6)     round <= 4'h6;
    else if (en_cpt) round <= round + 4'h1;
  end

  always @(negedge clk) begin
    if (counting) begin
      n_p12      += int'(p12);
      n_p6       += int'(p6);
      n_plain    += int'(en_plain);
      n_end_init += int'(end_init);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_outs(input string tag, input logic [12:0] want, input int budget);
    int n = 0;
    while (outs !== want && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(outs), 32'(want));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dv = 1'b0; tag_eq = 1'b0;
    repeat (2) tick();
    check("reset_outs", 32'(outs), 32'(O_IDLE));
    check("reset_index", 32'(block_index), 32'd0);
    rst = 1'b0;
    dv = 1'b1;
    tick();
    check("idle_ignores_valid", 32'(outs), 32'(O_IDLE));
    dv = 1'b0;

    // Initialisation walk with exact timing.
    counting = 1'b1;
    pulse_start();
    check("init_start", 32'(outs), 32'(O_INIT_ST));
    tick();
    check("init_run_r0", 32'(outs), 32'(O_RUN));
    check("init_round0", 32'(round), 32'h0);
    repeat (11) tick();
    check("init_round_last", 32'(round), 32'hB);
    check("init_run_rB", 32'(outs), 32'(O_RUN));
    tick();
    check("init_end_keyxor", 32'(outs), 32'(O_KEY_END));
    tick();
    check("end_init", 32'(outs), 32'(O_END_INIT));
    tick();
    check("ad_wait", 32'(outs), 32'(O_IDLE));
    repeat (2) tick();
    check("ad_wait_hold", 32'(outs), 32'(O_IDLE));

    // Full message, valid always high, matching tag.
    dv = 1'b1;
    tag_eq = 1'b1;
    tick();
    check("ad_start", 32'(outs), 32'(O_AD_ST));
    wait_outs("msg1_done", O_DONE_OK, 200);
    counting = 1'b0;
    check("cnt_p12", 32'(n_p12), 32'd2);
    check("cnt_p6", 32'(n_p6), 32'd4);
    check("cnt_plain", 32'(n_plain), 32'd4);
    check("cnt_end_init", 32'(n_end_init), 32'd1);
    check("msg1_index", 32'(block_index), 32'd3);
    tag_eq = 1'b0;
    repeat (3) tick();
    check("auth_held", 32'(outs), 32'(O_DONE_OK));

    // Restart clears status; stall in CT_WAIT; failing tag.
    pulse_start();
    check("restart_clear", 32'(outs), 32'(O_INIT_ST));
    check("restart_index", 32'(block_index), 32'd0);
    wait_outs("msg2_ct0", O_CT_ST, 100);
    dv = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ct_stall%0d", i), 32'(outs), 32'(O_IDLE));
      tick();
    end
    check("stall_index", 32'(block_index), 32'd1);
    dv = 1'b1;
    check("ct_resume", 32'(outs), 32'(O_IDLE));
    tick();
    check("ct1_start", 32'(outs), 32'(O_CT_ST));
    wait_outs("msg2_done_bad", O_DONE_BAD, 200);

    // Start while busy is ignored; reset mid-ciphertext returns to IDLE.
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", 32'(outs), 32'(O_RUN));
    wait_outs("msg3_ct0", O_CT_ST, 100);
    tick();
    wait_outs("msg3_ct1", O_CT_ST, 100);
    check("msg3_index", 32'(block_index), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrun_reset", 32'(outs), 32'(O_IDLE));
    check("midrun_reset_index", 32'(block_index), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_idle", 32'(outs), 32'(O_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
